// File: rtl/stream_recorder.sv
// Capture engine: records accepted receiver beats into a DEPTH-entry RAM and
// reports the valid region (limit/start_addr) plus full/overflow to the replayer.
module stream_recorder #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              stop,
    input  logic              clear,
    input  logic              wrap_mode,
    input  logic              ready,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_write,
    output logic [ADDR_W:0]   limit,
    output logic [ADDR_W-1:0] start_addr,
    output logic              recording,
    output logic              full,
    output logic              overflow
);

    localparam logic [ADDR_W:0] LIM_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECORD  = 2'd1,
        FULL_ST = 2'd2
    } state_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   limit_q, limit_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic              ovf_q, ovf_d;
    logic              circ_q, circ_d;
    wr_req_t           wr_q, wr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            limit_q  <= '0;
            start_q  <= '0;
            ovf_q    <= 1'b0;
            circ_q   <= 1'b0;
            wr_q     <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            limit_q  <= limit_d;
            start_q  <= start_d;
            ovf_q    <= ovf_d;
            circ_q   <= circ_d;
            wr_q     <= wr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        limit_d  = limit_q;
        start_d  = start_q;
        ovf_d    = ovf_q;
        circ_d   = circ_q;
        // address/data hold their last value; only the strobe drops
        wr_d     = wr_q;
        wr_d.vld = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d  = RECORD;
                    circ_d   = wrap_mode;
                    wr_ptr_d = '0;
                    limit_d  = '0;
                    start_d  = '0;
                    ovf_d    = 1'b0;
                end else if (clear) begin
                    limit_d = '0;
                    start_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            RECORD: begin
                if (ready) begin
                    wr_d.vld  = 1'b1;
                    wr_d.addr = wr_ptr_q;
                    wr_d.data = data_in;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    if (circ_q) begin
                        // buffer already holds DEPTH entries: this beat evicts the oldest
                        if (limit_q == LIM_MAX) begin
                            start_d = wr_ptr_q + 1'b1;
                            ovf_d   = 1'b1;
                        end else begin
                            limit_d = limit_q + 1'b1;
                        end
                    end else begin
                        limit_d = limit_q + 1'b1;
                        if ((limit_q + 1'b1) == LIM_MAX) state_d = FULL_ST;
                    end
                end
                if (stop) state_d = IDLE;
            end
            FULL_ST: begin
                if (ready) ovf_d = 1'b1;
                if (stop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_write  = wr_q.vld;
    assign mem_addr   = wr_q.addr;
    assign mem_data   = wr_q.data;
    assign limit      = limit_q;
    assign start_addr = start_q;
    assign overflow   = ovf_q;
    assign recording  = (state_q == RECORD);
    assign full       = (limit_q == LIM_MAX);

endmodule
